// File: rtl/wb_port_arbiter_if.sv
// Bus bundle for wb_port_arbiter: two producer request channels and the
// register-file write port. The arbiter uses the slave modport; the
// producers and the register file together form the master side.
interface wb_port_arbiter_if #(
    parameter int WORD_SIZE = 32
);
    // Requester A: execute-stage results
    logic                 a_valid;
    logic                 a_ready;
    logic [WORD_SIZE-1:0] a_data;
    logic [4:0]           a_rd;
    // Requester B: load-unit results
    logic                 b_valid;
    logic                 b_ready;
    logic [WORD_SIZE-1:0] b_data;
    logic [4:0]           b_rd;
    // Register-file write port
    logic [WORD_SIZE-1:0] write_data;
    logic [4:0]           write_addr;
    logic                 write_enable_out;
    logic                 busy;

    modport master (
        output a_valid, a_data, a_rd, b_valid, b_data, b_rd,
        input  a_ready, b_ready, write_data, write_addr, write_enable_out, busy
    );

    modport slave (
        input  a_valid, a_data, a_rd, b_valid, b_data, b_rd,
        output a_ready, b_ready, write_data, write_addr, write_enable_out, busy
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between the execute
// stage (requester A) and the load unit (requester B). Each requester feeds a
// 2-entry FIFO; a round-robin arbiter drains one head per cycle into a
// registered write port. Writes to x0 are consumed without a write strobe.
// Optional macro WB_ARB_STATS_EN adds conflict_count / stall_count outputs.
//
// Handshake: x_ready is high whenever queue x holds fewer than QUEUE_DEPTH
// entries and depends only on registered state. An entry is pushed on the
// rising clock edge where x_valid && x_ready; a producer holding x_valid
// while x_ready is low simply retries on later cycles.
module wb_port_arbiter #(
    parameter int WORD_SIZE   = 32,
    parameter int QUEUE_DEPTH = 2    // only 2 is supported
) (
    input  logic               clock,
    input  logic               reset,
    wb_port_arbiter_if.slave   bus
`ifdef WB_ARB_STATS_EN
    ,
    output logic [31:0]        conflict_count,
    output logic [31:0]        stall_count
`endif
);
    localparam int ENTRY_W = 5 + WORD_SIZE;

    // Index 0 = requester A, index 1 = requester B.
    logic [ENTRY_W-1:0] mem_q   [2][2];
    logic [1:0]         count_q [2];
    logic [1:0]         count_d [2];
    logic [1:0]         wptr_q;
    logic [1:0]         rptr_q;
    logic [ENTRY_W-1:0] req_entry [2];
    logic [ENTRY_W-1:0] head      [2];
    logic [1:0]         req_valid;
    logic [1:0]         req_ready;
    logic [1:0]         nonempty;
    logic [1:0]         push;
    logic [1:0]         pop;

    logic               last_grant_q;   // 0 = A granted last, 1 = B
    logic               grant_a;
    logic               grant_b;
    logic [ENTRY_W-1:0] gnt_entry;
    logic [4:0]         gnt_rd;
    logic [WORD_SIZE-1:0] gnt_data;

    logic [WORD_SIZE-1:0] wdata_q;
    logic [4:0]           waddr_q;
    logic                 we_q;

    // Gather requester inputs and derive queue status and push strobes.
    always_comb begin
        req_valid    = {bus.b_valid, bus.a_valid};
        req_entry[0] = {bus.a_rd, bus.a_data};
        req_entry[1] = {bus.b_rd, bus.b_data};
        for (int r = 0; r < 2; r++) begin
            nonempty[r]  = (count_q[r] != 2'd0);
            req_ready[r] = (count_q[r] < 2'(QUEUE_DEPTH));
            push[r]      = req_valid[r] && req_ready[r];
            head[r]      = mem_q[r][rptr_q[r]];
        end
    end

    // Round-robin grant: a lone non-empty queue wins; on conflict the side
    // that did not win last time wins.
    always_comb begin
        grant_a   = nonempty[0] && (!nonempty[1] || last_grant_q);
        grant_b   = nonempty[1] && !grant_a;
        pop       = {grant_b, grant_a};
        gnt_entry = grant_a ? head[0] : head[1];
        gnt_rd    = gnt_entry[ENTRY_W-1 -: 5];
        gnt_data  = gnt_entry[WORD_SIZE-1:0];
    end

    // Next occupancy per queue; push and pop may coincide.
    always_comb begin
        for (int r = 0; r < 2; r++) begin
            count_d[r] = count_q[r] + {1'b0, push[r]} - {1'b0, pop[r]};
        end
    end

    // Queue storage is not reset; occupancy and pointers say what is valid.
    always_ff @(posedge clock) begin
        for (int r = 0; r < 2; r++) begin
            if (push[r]) begin
                mem_q[r][wptr_q[r]] <= req_entry[r];
            end
        end
    end

    // Queue pointers, occupancy and round-robin history.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q[0]   <= 2'd0;
            count_q[1]   <= 2'd0;
            wptr_q       <= 2'b00;
            rptr_q       <= 2'b00;
            last_grant_q <= 1'b1;
        end else begin
            for (int r = 0; r < 2; r++) begin
                count_q[r] <= count_d[r];
                if (push[r]) wptr_q[r] <= ~wptr_q[r];
                if (pop[r])  rptr_q[r] <= ~rptr_q[r];
            end
            if (grant_a) begin
                last_grant_q <= 1'b0;
            end else if (grant_b) begin
                last_grant_q <= 1'b1;
            end
        end
    end

    // Registered write port: one strobe per granted non-x0 entry; an x0
    // entry clears address/data without strobing; idle cycles hold.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            we_q    <= 1'b0;
            waddr_q <= 5'd0;
            wdata_q <= '0;
        end else if (grant_a || grant_b) begin
            we_q    <= (gnt_rd != 5'd0);
            waddr_q <= gnt_rd;
            wdata_q <= (gnt_rd != 5'd0) ? gnt_data : '0;
        end else begin
            we_q    <= 1'b0;
        end
    end

    assign bus.a_ready          = req_ready[0];
    assign bus.b_ready          = req_ready[1];
    assign bus.write_data       = wdata_q;
    assign bus.write_addr       = waddr_q;
    assign bus.write_enable_out = we_q;
    assign bus.busy             = nonempty[0] || nonempty[1] || we_q;

`ifdef WB_ARB_STATS_EN
    logic [31:0] conflict_q;
    logic [31:0] stall_q;

    // Event counters: both heads valid, and any producer held off this cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            conflict_q <= 32'd0;
            stall_q    <= 32'd0;
        end else begin
            conflict_q <= conflict_q + 32'(&nonempty);
            stall_q    <= stall_q + 32'(|(req_valid & ~req_ready));
        end
    end

    assign conflict_count = conflict_q;
    assign stall_count    = stall_q;
`endif
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Testbench for wb_port_arbiter: directed scenarios plus a random phase,
// checked cycle by cycle against a transaction-level queue model.
module tb_wb_port_arbiter;
  localparam int W = 32;

  logic clk;
  logic rst;

  wb_port_arbiter_if #(.WORD_SIZE(W)) bus ();

`ifdef WB_ARB_STATS_EN
  logic [31:0] conflict_count;
  logic [31:0] stall_count;
`endif

  wb_port_arbiter #(.WORD_SIZE(W), .QUEUE_DEPTH(2)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
`ifdef WB_ARB_STATS_EN
    ,
    .conflict_count (conflict_count),
    .stall_count    (stall_count)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- scoreboard / model ----------------
  logic [36:0] ma_q[$];      // model queue A: {rd, data}
  logic [36:0] mb_q[$];      // model queue B
  logic [37:0] exp_q[$];     // expected {we, addr, data} per cycle
  bit          last_b;
  logic [4:0]  hold_addr;
  logic [31:0] hold_data;
  bit          mon_en = 0;
  int unsigned m_conf;
  int unsigned m_stall;

  task automatic model_reset();
    ma_q.delete();
    mb_q.delete();
    exp_q.delete();
    last_b    = 1;
    hold_addr = '0;
    hold_data = '0;
    m_conf    = 0;
    m_stall   = 0;
    exp_q.push_back('0);
  endtask

  task automatic monitor_step();
    logic [37:0] e;
    logic [37:0] o;
    logic [36:0] h;
    int sa;
    int sb;
    bit ga;
    bit gb;
    bit cur_we;
    cur_we = 0;
    h = '0;
    if (exp_q.size() == 0) begin
      check("sb_underflow", 64'(1), 64'(0));
    end else begin
      e = exp_q.pop_front();
      cur_we = e[37];
      check("wr_en",   64'(bus.write_enable_out), 64'(e[37]));
      check("wr_addr", 64'(bus.write_addr),       64'(e[36:32]));
      check("wr_data", 64'(bus.write_data),       64'(e[31:0]));
    end
    sa = ma_q.size();
    sb = mb_q.size();
    check("a_ready", 64'(bus.a_ready), 64'(sa < 2));
    check("b_ready", 64'(bus.b_ready), 64'(sb < 2));
    check("busy",    64'(bus.busy),    64'((sa != 0) || (sb != 0) || cur_we));
`ifdef WB_ARB_STATS_EN
    check("conflict_count", 64'(conflict_count), 64'(m_conf));
    check("stall_count",    64'(stall_count),    64'(m_stall));
    if (sa != 0 && sb != 0) m_conf++;
    if ((bus.a_valid && sa == 2) || (bus.b_valid && sb == 2)) m_stall++;
`endif
    ga = (sa != 0) && ((sb == 0) || last_b);
    gb = (sb != 0) && !ga;
    if (ga) begin
      h = ma_q.pop_front();
      last_b = 0;
    end else if (gb) begin
      h = mb_q.pop_front();
      last_b = 1;
    end
    if (ga || gb) begin
      if (h[36:32] != 5'd0) o = {1'b1, h};
      else                  o = '0;
      hold_addr = o[36:32];
      hold_data = o[31:0];
    end else begin
      o = {1'b0, hold_addr, hold_data};
    end
    exp_q.push_back(o);
    if (bus.a_valid && sa < 2) ma_q.push_back({bus.a_rd, bus.a_data});
    if (bus.b_valid && sb < 2) mb_q.push_back({bus.b_rd, bus.b_data});
  endtask

  always @(negedge clk) begin
    if (mon_en && !rst) monitor_step();
  end

  // ---------------- driver tasks ----------------
  // All drivers start and end #1 after a rising edge.
  task automatic drive_a(input logic [4:0] rd, input logic [31:0] data);
    bit r;
    int n;
    n = 0;
    bus.a_valid = 1'b1;
    bus.a_rd    = rd;
    bus.a_data  = data;
    do begin
      @(negedge clk);
      r = bus.a_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!r && n < 50);
    if (!r) check("a_push_timeout", 64'(0), 64'(1));
  endtask

  task automatic drive_b(input logic [4:0] rd, input logic [31:0] data);
    bit r;
    int n;
    n = 0;
    bus.b_valid = 1'b1;
    bus.b_rd    = rd;
    bus.b_data  = data;
    do begin
      @(negedge clk);
      r = bus.b_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!r && n < 50);
    if (!r) check("b_push_timeout", 64'(0), 64'(1));
  endtask

  task automatic idle_cycles(input int n);
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_idle();
    bit done;
    done = 0;
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(posedge clk);
      #1;
      if (!bus.busy && ma_q.size() == 0 && mb_q.size() == 0) done = 1;
    end
    check("idle_timeout", 64'(done), 64'(1));
    idle_cycles(2);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_we"},    64'(bus.write_enable_out), 64'(0));
    check({tag, "_addr"},  64'(bus.write_addr),       64'(0));
    check({tag, "_data"},  64'(bus.write_data),       64'(0));
    check({tag, "_busy"},  64'(bus.busy),             64'(0));
    check({tag, "_ready"}, 64'({bus.a_ready, bus.b_ready}), 64'(2'b11));
`ifdef WB_ARB_STATS_EN
    check({tag, "_conflict"}, 64'(conflict_count), 64'(0));
    check({tag, "_stall"},    64'(stall_count),    64'(0));
`endif
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    bus.a_valid = 1'b0;
    bus.a_rd    = '0;
    bus.a_data  = '0;
    bus.b_valid = 1'b0;
    bus.b_rd    = '0;
    bus.b_data  = '0;
    model_reset();
    #3;
    check_reset_outputs("por");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    mon_en = 1;
    idle_cycles(2);

    // 1: single A write
    drive_a(5'd5, 32'hDEADBEEF);
    bus.a_valid = 1'b0;
    wait_idle();

    // 2: simultaneous A and B, A wins first
    fork
      drive_a(5'd3, 32'h11);
      drive_b(5'd4, 32'h22);
    join
    wait_idle();

    // 3: sustained contention for 8 items per side
    fork
      begin
        for (int i = 0; i < 8; i++) drive_a(5'(i + 1), 32'hA000_0000 | 32'(i));
        bus.a_valid = 1'b0;
      end
      begin
        for (int i = 0; i < 8; i++) drive_b(5'(i + 16), 32'hB000_0000 | 32'(i));
        bus.b_valid = 1'b0;
      end
    join
    wait_idle();

    // 4: x0 drop on B followed by an A write
    drive_b(5'd0, 32'h55);
    bus.b_valid = 1'b0;
    drive_a(5'd7, 32'h77);
    bus.a_valid = 1'b0;
    wait_idle();

    // Random traffic with gaps and occasional x0 targets
    fork
      begin
        repeat (25) begin
          if ($urandom_range(0, 2) == 0) begin
            bus.a_valid = 1'b0;
            @(posedge clk);
            #1;
          end
          drive_a(5'($urandom_range(0, 31)), $urandom);
        end
        bus.a_valid = 1'b0;
      end
      begin
        repeat (25) begin
          if ($urandom_range(0, 2) == 0) begin
            bus.b_valid = 1'b0;
            @(posedge clk);
            #1;
          end
          drive_b(5'($urandom_range(0, 31)), $urandom);
        end
        bus.b_valid = 1'b0;
      end
    join
    wait_idle();

    // 5: reset with both queues full, asserted between edges
    bus.a_valid = 1'b1;
    bus.b_valid = 1'b1;
    bus.a_rd    = 5'd9;
    bus.b_rd    = 5'd10;
    repeat (4) begin
      bus.a_data = $urandom;
      bus.b_data = $urandom;
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #2;
    rst = 1'b1;
    mon_en = 0;
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    #1;
    check_reset_outputs("midrst");
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    mon_en = 1;
    idle_cycles(4);
    check_reset_outputs("postrst");
    drive_a(5'd12, 32'hCAFE_0012);
    bus.a_valid = 1'b0;
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
